// File: rtl/l1d_mshr_linefill_arb_pkg.sv
// Shared L1D types and constants for the MSHR linefill path: downstream request payload,
// bus request payload, and the linefill outstanding cap.
package l1d_mshr_linefill_arb_pkg;

   localparam int L1D_MSHR_ENTRY_NUM           = 8;
   localparam int L1D_LINEFILL_OUTSTANDING_MAX = 4;
   localparam int L1D_MSHR_ID_WIDTH            = $clog2(L1D_MSHR_ENTRY_NUM);
   localparam int L1D_TAG_WIDTH                = 20;
   localparam int L1D_INDEX_WIDTH              = 6;
   localparam int L1D_WAY_WIDTH                = 2;
   localparam int L1D_OFFSET_WIDTH             = 6;
   localparam int L1D_SB_PLD_WIDTH             = 16;

   typedef struct packed {
      logic [L1D_TAG_WIDTH-1:0]    tag;
      logic [L1D_WAY_WIDTH-1:0]    way;
      logic [L1D_INDEX_WIDTH-1:0]  index;
      logic [L1D_OFFSET_WIDTH-1:0] offset;
      logic [L1D_SB_PLD_WIDTH-1:0] sb_pld;
   } pack_l1d_mshr_downstream_req_pld;

   typedef struct packed {
      logic [L1D_TAG_WIDTH-1:0]     tag;
      logic [L1D_INDEX_WIDTH-1:0]   index;
      logic [L1D_MSHR_ID_WIDTH-1:0] id;
   } pack_l1d_bus_req_pld;

endpackage

// File: rtl/l1d_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
// Shared by the linefill, rw and evict request arbiters.
module l1d_rr_arb #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   logic [IDX_W-1:0] cand_idx;

   // N is a power of two, so the candidate index wraps by truncation.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      cand_idx  = '0;
      for (int k = 0; k < N; k++) begin
         cand_idx = ptr_i + IDX_W'(k);
         if (!gnt_vld_o && req_i[cand_idx]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = cand_idx;
         end
      end
      gnt_o = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;
   end

endmodule

// File: rtl/l1d_mshr_linefill_arb.sv
// Round-robin linefill arbiter between the MSHR entries and the bus, with per-entry
// outstanding tracking and done decode. L1D_LINEFILL_ARB_PERF_EN adds perf counters.
module l1d_mshr_linefill_arb
   import l1d_mshr_linefill_arb_pkg::*;
#(
   parameter int ENTRY_NUM       = L1D_MSHR_ENTRY_NUM,
   parameter int OUTSTANDING_MAX = L1D_LINEFILL_OUTSTANDING_MAX,
   parameter int ID_WIDTH        = $clog2(ENTRY_NUM),
   localparam int CNT_W          = $clog2(OUTSTANDING_MAX + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ENTRY_NUM-1:0]            v_downstream_req_vld,
   output logic [ENTRY_NUM-1:0]            v_downstream_req_rdy,
   input  pack_l1d_mshr_downstream_req_pld v_downstream_req_pld [ENTRY_NUM],
   output logic                            bus_req_vld,
   input  logic                            bus_req_rdy,
   output pack_l1d_bus_req_pld             bus_req_pld,
   input  logic                            bus_rsp_vld,
   output logic                            bus_rsp_rdy,
   input  logic [ID_WIDTH-1:0]             bus_rsp_id,
   input  logic                            bus_rsp_last,
   output logic [ENTRY_NUM-1:0]            v_linefill_done_en,
   output logic [CNT_W-1:0]                outstanding_cnt,
`ifdef L1D_LINEFILL_ARB_PERF_EN
   output logic [31:0]                     perf_grant_cnt,
   output logic [31:0]                     perf_cap_stall_cnt,
`endif
   output logic                            err_unexpected_rsp
);

   logic [ENTRY_NUM-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
   logic                 bus_vld_q, bus_vld_d;
   pack_l1d_bus_req_pld  bus_pld_q, bus_pld_d;
   logic                 err_q, err_d;

   logic [ENTRY_NUM-1:0] eligible, arb_gnt;
   logic [ID_WIDTH-1:0]  arb_idx;
   logic                 arb_vld, cap_ok, can_issue, grant, rsp_hit, rsp_miss;
   logic                 unused_pld;

   assign eligible  = v_downstream_req_vld & ~outstanding_q;
   assign cap_ok    = (cnt_q < CNT_W'(OUTSTANDING_MAX));
   assign can_issue = (!bus_vld_q || bus_req_rdy) && cap_ok;

   l1d_rr_arb #(.N(ENTRY_NUM), .IDX_W(ID_WIDTH)) u_rr_arb (
      .req_i     (eligible),
      .ptr_i     (ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   // Outstanding bits are read as registered, so an entry freed this cycle waits a cycle.
   always_comb begin
      grant                = !rst && arb_vld && can_issue;
      rsp_hit              = !rst && bus_rsp_vld && bus_rsp_last && outstanding_q[bus_rsp_id];
      rsp_miss             = bus_rsp_vld && bus_rsp_last && !outstanding_q[bus_rsp_id];
      v_downstream_req_rdy = grant ? arb_gnt : '0;
      v_linefill_done_en   = rsp_hit ? (ENTRY_NUM'(1) << bus_rsp_id) : '0;
      outstanding_d        = (outstanding_q & ~v_linefill_done_en) | v_downstream_req_rdy;
      cnt_d                = cnt_q + CNT_W'(grant) - CNT_W'(rsp_hit);
      ptr_d                = grant ? (arb_idx + ID_WIDTH'(1)) : ptr_q;
      err_d                = err_q | rsp_miss;
      bus_vld_d            = bus_vld_q && !bus_req_rdy;
      bus_pld_d            = bus_pld_q;
      if (grant) begin
         bus_vld_d       = 1'b1;
         bus_pld_d.tag   = v_downstream_req_pld[arb_idx].tag;
         bus_pld_d.index = v_downstream_req_pld[arb_idx].index;
         bus_pld_d.id    = L1D_MSHR_ID_WIDTH'(arb_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
         cnt_q         <= '0;
         ptr_q         <= '0;
         bus_vld_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         cnt_q         <= cnt_d;
         ptr_q         <= ptr_d;
         bus_vld_q     <= bus_vld_d;
         err_q         <= err_d;
      end
   end

   // Payload carries no reset; it is only meaningful while bus_req_vld is high.
   always_ff @(posedge clk) begin
      bus_pld_q <= bus_pld_d;
   end

   assign bus_req_vld        = bus_vld_q;
   assign bus_req_pld        = bus_pld_q;
   assign bus_rsp_rdy        = 1'b1;
   assign outstanding_cnt    = cnt_q;
   assign err_unexpected_rsp = err_q;

   always_comb begin
      unused_pld = 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         unused_pld = unused_pld ^ (^{v_downstream_req_pld[i].way,
                                      v_downstream_req_pld[i].offset,
                                      v_downstream_req_pld[i].sb_pld});
      end
   end

`ifdef L1D_LINEFILL_ARB_PERF_EN
   logic [31:0] perf_grant_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (grant && perf_grant_q != 32'hFFFF_FFFF) perf_grant_q <= perf_grant_q + 32'd1;
         if ((|eligible) && !cap_ok && perf_stall_q != 32'hFFFF_FFFF)
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_grant_cnt     = perf_grant_q;
   assign perf_cap_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/l1d_mshr_linefill_arb.md
Name: l1d_mshr_linefill_arb

Overview:
- Sits directly downstream of the per-entry MSHR state machines.
- Collects the linefill (downstream) requests from all L1D_MSHR_ENTRY_NUM entries and grants one per cycle, round-robin, into a registered bus request stage.
- Tracks which entries have a linefill outstanding on the bus and decodes bus responses back into the per-entry one-hot linefill_done_en pulses.

Parameters:
- ENTRY_NUM, L1D_MSHR_ENTRY_NUM (8): number of MSHR entries arbitrated; power of two, >= 2.
- OUTSTANDING_MAX, 4: maximum linefills in flight on the bus; 1..ENTRY_NUM.
- ID_WIDTH, $clog2(ENTRY_NUM): bus transaction id width; id = entry index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- v_downstream_req_vld  in  ENTRY_NUM  per-entry linefill request valid.
- v_downstream_req_rdy  out  ENTRY_NUM  per-entry grant; at most one bit set.
- v_downstream_req_pld  in  ENTRY_NUM x pack_l1d_mshr_downstream_req_pld  per-entry payload (tag, way, index, offset, sb_pld).
- bus_req_vld  out  1  registered bus request valid.
- bus_req_rdy  in  1  bus accepts request.
- bus_req_pld  out  pack_l1d_bus_req_pld  payload: {tag, index, id}.
- bus_rsp_vld  in  1  response beat valid.
- bus_rsp_rdy  out  1  tied 1; responses are never back-pressured.
- bus_rsp_id  in  ID_WIDTH  response id.
- bus_rsp_last  in  1  final beat of the linefill.
- v_linefill_done_en  out  ENTRY_NUM  one-cycle pulse to the owning entry.
- outstanding_cnt  out  $clog2(OUTSTANDING_MAX+1)  linefills in flight.
- err_unexpected_rsp  out  1  sticky; a response hit an id with no outstanding linefill.

Behaviour:
- Reset values:
  - bus_req_vld=0; pld register is don't-care.
  - outstanding bitmap=0; outstanding_cnt=0.
  - RR pointer=0; err_unexpected_rsp=0.
  - v_downstream_req_rdy=0; v_linefill_done_en=0.
- Reset mid-transfer drops all tracking. Responses arriving after reset for pre-reset ids raise err_unexpected_rsp.
- Eligibility: eligible[i] = v_downstream_req_vld[i] && !outstanding[i].
- Grant condition: can_issue = (!bus_req_vld || bus_req_rdy) && (outstanding_cnt < OUTSTANDING_MAX). The bus_req_rdy term gives full throughput.
- Arbitration: round-robin starting at the RR pointer. On grant to entry g:
  - v_downstream_req_rdy[g]=1 in the same cycle (combinational; the handshake completes that cycle).
  - bus_req_pld <= {pld[g].tag, pld[g].index, g} and bus_req_vld <= 1 next cycle.
  - outstanding[g] <= 1.
  - pointer <= (g+1) mod ENTRY_NUM; wraps ENTRY_NUM-1 -> 0.
- No eligible request or !can_issue: pointer holds, no rdy asserted.
- bus_req_vld && !bus_req_rdy: the register holds; pld must be stable until accepted.
- Bus request handshake: bus_req_vld <= 0 unless a new grant occurs the same cycle.
- Counter rule: outstanding_cnt increments on grant (not on bus handshake), so the cap covers the request register.
- Response handling, valid cycle with last=1 and outstanding[id]=1:
  - v_linefill_done_en[id]=1 in the same cycle (combinational).
  - outstanding[id] <= 0; cnt decrements.
- Response with last=1 and outstanding[id]=0: no pulse, err_unexpected_rsp <= 1. Non-last beats have no effect.
- Simultaneous grant and response completion:
  - cnt unchanged (+1 -1).
  - If the response frees entry k, entry k is not eligible until the next cycle (outstanding read as registered).
- cnt == OUTSTANDING_MAX: no grants. The cap is released the cycle after a completing response.
- Arbitration is combinational; all state changes are registered.

Optional Feature:
- Macro: L1D_LINEFILL_ARB_PERF_EN.
- Defined: adds outputs perf_grant_cnt[31:0] and perf_cap_stall_cnt[31:0], both saturating at 32'hFFFF_FFFF and reset to 0.
  - perf_grant_cnt counts grants.
  - perf_cap_stall_cnt counts cycles where any eligible request exists but cnt == OUTSTANDING_MAX.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- l1d_package gains:
  - pack_l1d_bus_req_pld (tag L1D_TAG_WIDTH, index L1D_INDEX_WIDTH, id).
  - L1D_LINEFILL_OUTSTANDING_MAX.
  - L1D_MSHR_ID_WIDTH.
- pack_l1d_mshr_downstream_req_pld is reused unchanged.
- One sub-module: l1d_rr_arb (ENTRY_NUM-wide request vector, pointer in, one-hot grant out, granted index out), reusable for the rw and evict request arbiters.

Test Plan:
- Entries 1, 3, 6 request simultaneously; pointer=0; bus_req_rdy=1.
  -> Grants 1, 3, 6 in consecutive cycles; bus ids 1, 3, 6; cnt reaches 3.
- All 8 entries request; OUTSTANDING_MAX=4; no responses.
  -> Exactly 4 grants (0..3), then rdy stays 0; cnt=4.
  -> Response id=2 last=1 gives v_linefill_done_en=8'b0000_0100; entry 4 is granted the following cycle.
- bus_req_rdy held 0 for 5 cycles with entry 5 pending.
  -> bus_req_vld=1 and pld id=5 stable throughout; no new grant; accepted when rdy=1.
- Response id=7 last=1 with no outstanding on 7.
  -> No done pulse; err_unexpected_rsp=1 and stays 1 until rst.
- Same cycle: grant to entry 2 and completing response id=0.
  -> cnt unchanged; outstanding bits 0->0 and 2->1; entry 0 re-requesting is not granted that cycle.
- rst asserted mid-burst (cnt=3, bus_req_vld=1).
  -> Next cycle all outputs are at reset values; pointer=0.
